vector_line_drawer: RTL
=======================

VECTOR_LINE_DRAWER -- requirements
Module: vector_line_drawer

Interface
REQ-001 SHALL have parameter CH_WIDTH, default 8, width of every coordinate and of x_ch/y_ch.
REQ-002 SHALL have parameter DWELL_W, default 8, width of the dwell input.
REQ-003 SHALL have port clk input 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst input 1, asynchronous, active-low reset.
REQ-005 SHALL have port enable input 1; high = run, low = pause.
REQ-006 SHALL have port seg_valid input 1; the upstream segment is valid.
REQ-007 SHALL have port seg_ready output 1; the block accepts a segment.
REQ-008 SHALL have ports seg_x0, seg_y0, seg_x1, seg_y1 input CH_WIDTH each; unsigned start and end coordinates.
REQ-009 SHALL have port seg_blank input 1; 1 = beam-off move, 0 = drawn line.
REQ-010 SHALL have port dwell input DWELL_W; each point is held for dwell+1 cycles.
REQ-011 SHALL have ports x_ch, y_ch output CH_WIDTH each; registered beam position, driven straight to the DACs.
REQ-012 SHALL have port blank output 1; registered beam-off flag.
REQ-013 SHALL have port done output 1; single-cycle pulse when a segment completes.

Function
REQ-014 SHALL have states IDLE and DRAW; seg_ready = (state==IDLE) && enable.
REQ-015 SHALL accept a segment only on a cycle where seg_valid && seg_ready; it latches all seg_* inputs and dwell, and moves to DRAW.
REQ-016 SHALL, on the cycle after acceptance, present the first point on x_ch/y_ch (latency 1), with blank = latched seg_blank.
REQ-017 SHALL, for a drawn segment, step the points using integer Bresenham over all octants:
  - dx = |x1-x0|, dy = -|y1-y0|, err = dx+dy, sx/sy = ±1 toward the endpoint.
  - Per step: e2 = 2*err; if e2>=dy then err+=dy, x+=sx; if e2<=dx then err+=dx, y+=sy.
REQ-018 SHALL hold the error arithmetic signed, at CH_WIDTH+2 bits, with no overflow for any coordinate pair.
REQ-019 SHALL emit max(dx,|dy|)+1 points for a drawn segment; the first point is (x0,y0) and the last is exactly (x1,y1).
REQ-020 SHALL, for a blanked segment, output the single point (x1,y1) with blank=1; no interpolation.
REQ-021 SHALL hold each point for dwell+1 enabled cycles, using a dwell counter reloaded at every point.
REQ-022 SHALL treat a degenerate segment (x0==x1 and y0==y1) as one point.
REQ-023 SHALL, after the last point's hold expires:
  - Return to IDLE.
  - Pulse done for exactly that one cycle, with seg_ready high in the same cycle when enable=1.
  - Allow a new segment to be accepted in the same cycle.
REQ-024 SHALL keep x_ch/y_ch/blank at the last point while in IDLE.
REQ-025 SHALL, with enable=0:
  - Freeze the dwell counter, stepping and state.
  - Hold all outputs.
  - Keep seg_ready at 0 and done at 0.
  - On enable=1, resume with no lost or repeated cycles.
REQ-026 SHALL ignore seg_* input changes while in DRAW.

Reset
REQ-027 SHALL, while rst=0 (asynchronously and regardless of clk), force:
  - State to IDLE.
  - x_ch=0, y_ch=0, blank=1, done=0, seg_ready=0.
  - All internal counters and error terms to 0.
REQ-028 SHALL, on the first clk edge after rst rises, drive seg_ready = enable.
REQ-029 SHALL, when rst falls mid-segment, abort the segment without a done pulse; no partial state survives reset.

Verification
REQ-030 SHALL be verified for a horizontal line: (10,20)->(13,20), dwell=0, enable=1 -> x_ch 10,11,12,13 on four consecutive cycles, y_ch=20, blank=0, done on the cycle after 13.
REQ-031 SHALL be verified for a steep line: (0,0)->(2,5), dwell=1 -> points (0,0),(0,1),(1,2),(1,3),(2,4),(2,5), each held exactly 2 cycles, one done pulse.
REQ-032 SHALL be verified for a reverse line plus back-to-back handshake: (5,5)->(3,5), with the next segment valid at done -> x 5,4,3, and the second segment's first point appears on the cycle after done.
REQ-033 SHALL be verified for a blanked move: (0,0)->(200,100), seg_blank=1, dwell=3 -> (200,100) held 4 cycles with blank=1, then done.
REQ-034 SHALL be verified for pause: enable low for 5 cycles mid-line -> outputs frozen for exactly those 5 cycles, and the total point sequence is unchanged.
REQ-035 SHALL be verified for reset mid-line: rst=0 during DRAW -> outputs immediately 0,0 with blank=1, no done pulse, IDLE after release.

Source files
------------

// File: rtl/vector_line_drawer.sv
// Vector line drawer: accepts (x0,y0)->(x1,y1) segments and steps the beam along them
// with integer Bresenham, holding every point for dwell+1 enabled cycles.
module vector_line_drawer #(
  parameter int CH_WIDTH = 8,
  parameter int DWELL_W  = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic                seg_valid,
  output logic                seg_ready,
  input  logic [CH_WIDTH-1:0] seg_x0,
  input  logic [CH_WIDTH-1:0] seg_y0,
  input  logic [CH_WIDTH-1:0] seg_x1,
  input  logic [CH_WIDTH-1:0] seg_y1,
  input  logic                seg_blank,
  input  logic [DWELL_W-1:0]  dwell,
  output logic [CH_WIDTH-1:0] x_ch,
  output logic [CH_WIDTH-1:0] y_ch,
  output logic                blank,
  output logic                done
);
  localparam int EW = CH_WIDTH + 2;
  localparam logic [CH_WIDTH-1:0] ONE_C = CH_WIDTH'(1);

  typedef enum logic {IDLE = 1'b0, DRAW = 1'b1} state_t;

  state_t                state_r;
  logic                  idle_r;
  logic [CH_WIDTH-1:0]   x1_r;
  logic [CH_WIDTH-1:0]   y1_r;
  logic [DWELL_W-1:0]    dwell_r;
  logic [DWELL_W-1:0]    dwell_cnt_r;
  logic signed [EW-1:0]  dx_r;
  logic signed [EW-1:0]  dy_r;
  logic signed [EW-1:0]  err_r;
  logic                  sx_neg_r;
  logic                  sy_neg_r;

  logic                  accept_s;
  logic                  at_end_s;
  logic                  step_x_s;
  logic                  step_y_s;
  logic [CH_WIDTH-1:0]   adx_s;
  logic [CH_WIDTH-1:0]   ady_s;
  logic signed [EW-1:0]  adx_ext_s;
  logic signed [EW-1:0]  ady_ext_s;
  logic signed [EW-1:0]  e2_s;
  logic signed [EW-1:0]  err_next_s;

  // idle_r stays low until the first edge after reset so seg_ready comes up one cycle late
  assign seg_ready = idle_r && enable;

  // Handshake, endpoint detection and one Bresenham step of the error term
  always_comb begin
    accept_s = seg_valid && seg_ready;
    at_end_s = (x_ch == x1_r) && (y_ch == y1_r);
    if (seg_x1 >= seg_x0) begin
      adx_s = seg_x1 - seg_x0;
    end else begin
      adx_s = seg_x0 - seg_x1;
    end
    if (seg_y1 >= seg_y0) begin
      ady_s = seg_y1 - seg_y0;
    end else begin
      ady_s = seg_y0 - seg_y1;
    end
    adx_ext_s  = $signed({2'b00, adx_s});
    ady_ext_s  = $signed({2'b00, ady_s});
    e2_s       = $signed({err_r[EW-2:0], 1'b0});
    step_x_s   = (e2_s >= dy_r);
    step_y_s   = (e2_s <= dx_r);
    err_next_s = err_r + (step_x_s ? dy_r : $signed({EW{1'b0}}))
                       + (step_y_s ? dx_r : $signed({EW{1'b0}}));
  end

  // Segment FSM, dwell timing and beam position registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= IDLE;
      idle_r      <= 1'b0;
      x1_r        <= {CH_WIDTH{1'b0}};
      y1_r        <= {CH_WIDTH{1'b0}};
      dwell_r     <= {DWELL_W{1'b0}};
      dwell_cnt_r <= {DWELL_W{1'b0}};
      dx_r        <= {EW{1'b0}};
      dy_r        <= {EW{1'b0}};
      err_r       <= {EW{1'b0}};
      sx_neg_r    <= 1'b0;
      sy_neg_r    <= 1'b0;
      x_ch        <= {CH_WIDTH{1'b0}};
      y_ch        <= {CH_WIDTH{1'b0}};
      blank       <= 1'b1;
      done        <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_r)
        IDLE: begin
          idle_r <= 1'b1;
          if (accept_s) begin
            state_r     <= DRAW;
            idle_r      <= 1'b0;
            x1_r        <= seg_x1;
            y1_r        <= seg_y1;
            dwell_r     <= dwell;
            dwell_cnt_r <= dwell;
            dx_r        <= adx_ext_s;
            dy_r        <= -ady_ext_s;
            err_r       <= adx_ext_s - ady_ext_s;
            sx_neg_r    <= (seg_x1 < seg_x0);
            sy_neg_r    <= (seg_y1 < seg_y0);
            blank       <= seg_blank;
            // A blanked move jumps straight to the endpoint, which is then also the last point
            if (seg_blank) begin
              x_ch <= seg_x1;
              y_ch <= seg_y1;
            end else begin
              x_ch <= seg_x0;
              y_ch <= seg_y0;
            end
          end
        end
        DRAW: begin
          if (enable) begin
            if (dwell_cnt_r != {DWELL_W{1'b0}}) begin
              dwell_cnt_r <= dwell_cnt_r - DWELL_W'(1);
            end else if (at_end_s) begin
              state_r <= IDLE;
              idle_r  <= 1'b1;
              done    <= 1'b1;
            end else begin
              dwell_cnt_r <= dwell_r;
              err_r       <= err_next_s;
              if (step_x_s) begin
                x_ch <= sx_neg_r ? (x_ch - ONE_C) : (x_ch + ONE_C);
              end
              if (step_y_s) begin
                y_ch <= sy_neg_r ? (y_ch - ONE_C) : (y_ch + ONE_C);
              end
            end
          end
        end
        default: begin
          state_r <= IDLE;
          idle_r  <= 1'b0;
        end
      endcase
    end
  end

endmodule
